// File: rtl/sad_pkg.sv
// Shared definitions for the SAD search dispatcher: default geometry, FSM encoding
// and the positions-per-axis helper.
package sad_pkg;

   localparam int unsigned NUM_CORES = 8;
   localparam int unsigned COORD_W   = 8;
   localparam int unsigned FRAME_DIM = 64;
   localparam int unsigned WIN_DIM   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Candidate block positions along one axis of the search frame.
   function automatic int unsigned positions_per_axis(input int unsigned frame_dim,
                                                      input int unsigned win_dim);
      return frame_dim - win_dim + 1;
   endfunction

endpackage

// File: rtl/rr_free_picker.sv
// Round-robin selector over the free-core mask; search begins one past the last
// granted core, or past the core being granted this cycle when a transfer happens.
module rr_free_picker #(
   parameter int unsigned N = 8,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     free,
   input  logic             upd,
   input  logic [IDX_W-1:0] upd_idx,
   output logic [N-1:0]     grant_c,
   output logic [IDX_W-1:0] grant_idx_c
);

   logic [IDX_W-1:0] ptr_q;

   // Pointer starts at the top index so the first grant after reset is core 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= IDX_W'(N - 1);
      end else if (upd) begin
         ptr_q <= upd_idx;
      end
   end

   always_comb begin
      logic        found;
      int unsigned base_i;
      int unsigned cand;
      grant_c     = '0;
      grant_idx_c = '0;
      found       = 1'b0;
      cand        = 0;
      base_i      = 32'(upd ? upd_idx : ptr_q);
      for (int unsigned k = 1; k <= N; k++) begin
         cand = (base_i + k) % N;
         if (!found && free[IDX_W'(cand)]) begin
            found                   = 1'b1;
            grant_c[IDX_W'(cand)]   = 1'b1;
            grant_idx_c             = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/sad_search_dispatcher.sv
// Walks every candidate block position of a search window and hands each one to a
// free SAD core, tracking busy cores and signalling completion once all have drained.
module sad_search_dispatcher
   import sad_pkg::*;
#(
   parameter int unsigned NUM_CORES = sad_pkg::NUM_CORES,
   parameter int unsigned FRAME_DIM = sad_pkg::FRAME_DIM,
   parameter int unsigned WIN_DIM   = sad_pkg::WIN_DIM,
   parameter int unsigned COORD_W   = sad_pkg::COORD_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [NUM_CORES-1:0] issue_valid,
   input  logic [NUM_CORES-1:0] issue_ready,
   output logic [COORD_W-1:0]   issue_row,
   output logic [COORD_W-1:0]   issue_col,
   input  logic [NUM_CORES-1:0] result_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 proto_err
);

   localparam int unsigned IDX_W = $clog2(NUM_CORES);
   localparam int unsigned LAST  = positions_per_axis(FRAME_DIM, WIN_DIM) - 1;
   localparam logic [COORD_W-1:0] LAST_C = COORD_W'(LAST);

   if (LAST > (2 ** COORD_W) - 1) begin : g_coord_w_check
      $error("sad_search_dispatcher: last position does not fit in COORD_W bits");
   end
   if (NUM_CORES < 2) begin : g_num_cores_check
      $error("sad_search_dispatcher: NUM_CORES must be at least 2");
   end

   state_t               state_q, state_n;
   logic [NUM_CORES-1:0] offer_q, offer_n;
   logic [IDX_W-1:0]     offer_idx_q, offer_idx_n;
   logic [NUM_CORES-1:0] core_busy_q, core_busy_n;
   logic [COORD_W-1:0]   row_q, row_n, col_q, col_n;
   logic                 proto_err_q, proto_err_n;
   logic                 pass_busy_q, pass_busy_n;
   logic                 done_q, done_n;

   logic                 xfer_c;
   logic                 spurious_c;
   logic                 last_pos_c;
   logic [NUM_CORES-1:0] xfer_mask_c;
   logic [NUM_CORES-1:0] free_c;
   logic [NUM_CORES-1:0] grant_c;
   logic [IDX_W-1:0]     grant_idx_c;

   // A core is free if idle, or returning its result this cycle, and not being loaded now.
   always_comb begin
      xfer_c      = |(offer_q & issue_ready);
      xfer_mask_c = xfer_c ? offer_q : '0;
      spurious_c  = |(result_valid & ~core_busy_q);
      last_pos_c  = (row_q == LAST_C) && (col_q == LAST_C);
      free_c      = ~(core_busy_q & ~result_valid) & ~xfer_mask_c;
   end

   rr_free_picker #(
      .N (NUM_CORES)
   ) u_picker (
      .clk         (clk),
      .rst         (rst),
      .free        (free_c),
      .upd         (xfer_c),
      .upd_idx     (offer_idx_q),
      .grant_c     (grant_c),
      .grant_idx_c (grant_idx_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         offer_q     <= '0;
         offer_idx_q <= '0;
         core_busy_q <= '0;
         row_q       <= '0;
         col_q       <= '0;
         proto_err_q <= 1'b0;
         pass_busy_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_n;
         offer_q     <= offer_n;
         offer_idx_q <= offer_idx_n;
         core_busy_q <= core_busy_n;
         row_q       <= row_n;
         col_q       <= col_n;
         proto_err_q <= proto_err_n;
         pass_busy_q <= pass_busy_n;
         done_q      <= done_n;
      end
   end

   always_comb begin
      state_n     = state_q;
      offer_n     = offer_q;
      offer_idx_n = offer_idx_q;
      row_n       = row_q;
      col_n       = col_q;
      core_busy_n = (core_busy_q & ~result_valid) | xfer_mask_c;
      proto_err_n = proto_err_q | spurious_c;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_n     = ST_ISSUE;
               row_n       = '0;
               col_n       = '0;
               proto_err_n = spurious_c;
               offer_n     = grant_c;
               offer_idx_n = grant_idx_c;
            end
         end
         ST_ISSUE: begin
            if (xfer_c) begin
               if (last_pos_c) begin
                  state_n = ST_DRAIN;
                  offer_n = '0;
               end else begin
                  if (col_q == LAST_C) begin
                     col_n = '0;
                     if (row_q != LAST_C) begin
                        row_n = row_q + COORD_W'(1);
                     end
                  end else begin
                     col_n = col_q + COORD_W'(1);
                  end
                  offer_n     = grant_c;
                  offer_idx_n = grant_idx_c;
               end
            end else if (offer_q == '0) begin
               offer_n     = grant_c;
               offer_idx_n = grant_idx_c;
            end
         end
         ST_DRAIN: begin
            if ((core_busy_q & ~result_valid) == '0) begin
               state_n = ST_DONE;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      pass_busy_n = (state_n == ST_ISSUE) || (state_n == ST_DRAIN);
      done_n      = (state_n == ST_DONE);
   end

   assign issue_valid = offer_q;
   assign issue_row   = row_q;
   assign issue_col   = col_q;
   assign busy        = pass_busy_q;
   assign done        = done_q;
   assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_sad_search_dispatcher.sv
// Scoreboard bench for sad_search_dispatcher: a 3x3 search (8 cores and 2 cores),
// expected transfers queued by the stimulus and checked by an independent monitor.
module tb_sad_search_dispatcher;

   typedef struct {
      int core;
      int row;
      int col;
   } exp_t;

   typedef struct {
      int core;
      int due;
   } job_t;

   logic       clk;
   logic       rst;
   logic       rst2;
   logic       start8;
   logic       start2;
   logic [7:0] iv8, ready8, rv8;
   logic [1:0] iv2, ready2, rv2;
   logic [7:0] row8, col8, row2, col2;
   logic       busy8, done8, perr8;
   logic       busy2, done2, perr2;

   int   checks;
   int   failures;
   int   cyc;
   int   done_cnt8;
   bit   auto_res;
   exp_t exp8[$];
   exp_t exp2[$];
   job_t pend[$];

   sad_search_dispatcher #(
      .NUM_CORES (8),
      .FRAME_DIM (6),
      .WIN_DIM   (4),
      .COORD_W   (8)
   ) dut8 (
      .clk          (clk),
      .rst          (rst),
      .start        (start8),
      .issue_valid  (iv8),
      .issue_ready  (ready8),
      .issue_row    (row8),
      .issue_col    (col8),
      .result_valid (rv8),
      .busy         (busy8),
      .done         (done8),
      .proto_err    (perr8)
   );

   sad_search_dispatcher #(
      .NUM_CORES (2),
      .FRAME_DIM (6),
      .WIN_DIM   (4),
      .COORD_W   (8)
   ) dut2 (
      .clk          (clk),
      .rst          (rst2),
      .start        (start2),
      .issue_valid  (iv2),
      .issue_ready  (ready2),
      .issue_row    (row2),
      .issue_col    (col2),
      .result_valid (rv2),
      .busy         (busy2),
      .done         (done2),
      .proto_err    (perr2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one cycle; a modelled core returns its result three cycles after accepting.
   task automatic tick();
      logic [7:0] x;
      job_t       keep[$];
      job_t       j;
      x = iv8 & ready8;
      @(posedge clk);
      #1;
      cyc++;
      rv8 = '0;
      foreach (pend[k]) begin
         if (pend[k].due == cyc) rv8[3'(pend[k].core)] = 1'b1;
         else keep.push_back(pend[k]);
      end
      pend = keep;
      if (auto_res) begin
         for (int i = 0; i < 8; i++) begin
            if (x[i]) begin
               j.core = i;
               j.due  = cyc + 3;
               pend.push_back(j);
            end
         end
      end
   endtask

   task automatic push8(input int core, input int row, input int col);
      exp_t e;
      e.core = core;
      e.row  = row;
      e.col  = col;
      exp8.push_back(e);
   endtask

   task automatic push2(input int core, input int row, input int col);
      exp_t e;
      e.core = core;
      e.row  = row;
      e.col  = col;
      exp2.push_back(e);
   endtask

   // Nine positions in row-major order, cores rotating from first_core.
   task automatic push_pass8(input int first_core);
      for (int i = 0; i < 9; i++) push8((first_core + i) % 8, i / 3, i % 3);
   endtask

   task automatic wait_done8(input string tag);
      logic prev_busy;
      bit   seen;
      seen      = 1'b0;
      prev_busy = busy8;
      for (int k = 0; k < 200 && !seen; k++) begin
         tick();
         if (done8) begin
            seen = 1'b1;
            check({tag, "_busy_low_with_done"}, 32'(busy8), 32'(0));
            check({tag, "_busy_high_before_done"}, 32'(prev_busy), 32'(1));
         end
         prev_busy = busy8;
      end
      check({tag, "_done_seen"}, 32'(seen), 32'(1));
      repeat (4) tick();
      check({tag, "_done_count"}, 32'(done_cnt8), 32'(1));
      check({tag, "_all_transfers_seen"}, 32'(exp8.size()), 32'(0));
      check({tag, "_idle_busy"}, 32'(busy8), 32'(0));
   endtask

   // Monitor: every handshake is popped against the scoreboard queue.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && ((iv8 & ready8) != 8'h00)) begin
         if (exp8.size() == 0) begin
            check("xfer8_unexpected", 32'(iv8), 32'(0));
         end else begin
            e = exp8.pop_front();
            check("xfer8_core", 32'(iv8), 32'(1) << e.core);
            check("xfer8_row", 32'(row8), 32'(e.row));
            check("xfer8_col", 32'(col8), 32'(e.col));
         end
      end
      if (!rst2 && ((iv2 & ready2) != 2'b00)) begin
         if (exp2.size() == 0) begin
            check("xfer2_unexpected", 32'(iv2), 32'(0));
         end else begin
            e = exp2.pop_front();
            check("xfer2_core", 32'(iv2), 32'(1) << e.core);
            check("xfer2_row", 32'(row2), 32'(e.row));
            check("xfer2_col", 32'(col2), 32'(e.col));
         end
      end
      if (done8) done_cnt8++;
   end

   initial begin
      checks    = 0;
      failures  = 0;
      cyc       = 0;
      done_cnt8 = 0;
      auto_res  = 1'b0;
      rst       = 1'b1;
      rst2      = 1'b1;
      start8    = 1'b0;
      start2    = 1'b0;
      ready8    = '0;
      ready2    = '0;
      rv8       = '0;
      rv2       = '0;
      tick();
      tick();

      // Reset state
      check("rst_issue_valid", 32'(iv8), 32'(0));
      check("rst_row", 32'(row8), 32'(0));
      check("rst_col", 32'(col8), 32'(0));
      check("rst_busy", 32'(busy8), 32'(0));
      check("rst_done", 32'(done8), 32'(0));
      check("rst_proto_err", 32'(perr8), 32'(0));
      rst  = 1'b0;
      rst2 = 1'b0;
      tick();

      // Pass 1: ready tied high, first offer one cycle after start
      auto_res  = 1'b1;
      ready8    = 8'hFF;
      done_cnt8 = 0;
      push_pass8(0);
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      check("p1_first_offer", 32'(iv8), 32'h01);
      check("p1_busy", 32'(busy8), 32'(1));
      check("p1_first_row", 32'(row8), 32'(0));
      check("p1_first_col", 32'(col8), 32'(0));
      wait_done8("p1");

      // Pass 2: core 0 withholds ready; offer must stay put
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ready8    = 8'hFE;
      done_cnt8 = 0;
      push_pass8(0);
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("p2_hold_valid", 32'(iv8), 32'h01);
         check("p2_hold_row", 32'(row8), 32'(0));
         check("p2_hold_col", 32'(col8), 32'(0));
         tick();
      end
      ready8 = 8'hFF;
      wait_done8("p2");

      // Reset after four transfers, then a stale result flags a protocol error
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      auto_res = 1'b0;
      for (int i = 0; i < 4; i++) push8(i, i / 3, i % 3);
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (4) tick();
      check("p3_four_transfers", 32'(exp8.size()), 32'(0));
      check("p3_offer_pending", 32'(iv8), 32'h10);
      rst = 1'b1;
      #1;
      check("p3_rst_valid", 32'(iv8), 32'(0));
      check("p3_rst_busy", 32'(busy8), 32'(0));
      check("p3_rst_row", 32'(row8), 32'(0));
      check("p3_rst_col", 32'(col8), 32'(0));
      tick();
      rst = 1'b0;
      rv8 = 8'h01;
      tick();
      check("p3_stale_result_err", 32'(perr8), 32'(1));
      check("p3_idle_no_offer", 32'(iv8), 32'(0));

      // Pass 4: fresh start from (0,0) clears the error; start in DRAIN is ignored
      auto_res  = 1'b1;
      done_cnt8 = 0;
      push_pass8(0);
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      check("p4_err_cleared", 32'(perr8), 32'(0));
      check("p4_first_offer", 32'(iv8), 32'h01);
      check("p4_first_row", 32'(row8), 32'(0));
      check("p4_first_col", 32'(col8), 32'(0));
      for (int k = 0; k < 100 && exp8.size() != 0; k++) tick();
      check("p4_reached_drain", 32'(exp8.size()), 32'(0));
      tick();
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      check("p4_drain_busy", 32'(busy8), 32'(1));
      check("p4_drain_no_offer", 32'(iv8), 32'(0));
      wait_done8("p4");

      // Spurious result in IDLE is sticky until the next start
      rv8 = 8'h20;
      tick();
      check("p5_spurious_err", 32'(perr8), 32'(1));
      repeat (3) tick();
      check("p5_err_sticky", 32'(perr8), 32'(1));
      done_cnt8 = 0;
      push_pass8(1);
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      check("p5_err_cleared", 32'(perr8), 32'(0));
      check("p5_rr_continues", 32'(iv8), 32'h02);
      wait_done8("p5");

      // Two cores, results withheld: offers stop until a core frees up
      ready2 = 2'b11;
      push2(0, 0, 0);
      push2(1, 0, 1);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      check("d2_offer0", 32'(iv2), 32'h1);
      tick();
      check("d2_offer1", 32'(iv2), 32'h2);
      tick();
      for (int k = 0; k < 3; k++) begin
         check("d2_all_busy_no_offer", 32'(iv2), 32'(0));
         tick();
      end
      check("d2_transfers_seen", 32'(exp2.size()), 32'(0));
      push2(0, 0, 2);
      rv2 = 2'b01;
      tick();
      rv2 = 2'b00;
      check("d2_resume_valid", 32'(iv2), 32'h1);
      check("d2_resume_row", 32'(row2), 32'(0));
      check("d2_resume_col", 32'(col2), 32'(2));
      tick();
      check("d2_third_transfer", 32'(exp2.size()), 32'(0));
      check("d2_full_again", 32'(iv2), 32'(0));
      check("d2_busy", 32'(busy2), 32'(1));
      rst2 = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
